// File: rtl/codificador_botoes_pkg.sv
// ============================================================================
//  Module   : codificador_botoes_pkg
//  Purpose  : Shared constants, encoder state type and note-code helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package codificador_botoes_pkg;

    localparam logic [3:0] NENHUMA_TECLA = 4'd0;
    localparam int         NUM_TECLAS    = 12;

    typedef enum logic [0:0] {
        LIVRE = 1'b0,
        PRESA = 1'b1
    } estado_t;

    // Note i is reported as i+1 so that 0 can mean "no note".
    function automatic logic [3:0] encode(input logic [3:0] indice);
        return indice + 4'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/codificador_botoes_if.sv
// ============================================================================
//  Module   : codificador_botoes_if
//  Purpose  : Raw key inputs and encoded/debounced outputs of the keyboard front-end.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface codificador_botoes_if;
    import codificador_botoes_pkg::*;

    logic [NUM_TECLAS-1:0]   botoes_raw;
    logic                    right_arrow_raw;
    logic                    left_arrow_raw;
    logic [3:0]              botoes_encoded;
    logic                    tecla_valida;
    logic                    right_arrow_pressed;
    logic                    left_arrow_pressed;
    logic [NUM_TECLAS+1:0]   db_estaveis;

    modport master (
        output botoes_raw, right_arrow_raw, left_arrow_raw,
        input  botoes_encoded, tecla_valida, right_arrow_pressed,
               left_arrow_pressed, db_estaveis
    );

    modport slave (
        input  botoes_raw, right_arrow_raw, left_arrow_raw,
        output botoes_encoded, tecla_valida, right_arrow_pressed,
               left_arrow_pressed, db_estaveis
    );

endinterface

`default_nettype wire

// File: rtl/codificador_botoes_debouncer.sv
// ============================================================================
//  Module   : debouncer
//  Purpose  : 2-FF synchroniser plus counter-based debounce of one key.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit ATIVO_BAIXO     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic estavel
);

    localparam int             c_largura = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_largura-1:0] c_ultimo = c_largura'(DEBOUNCE_CYCLES - 1);

    logic                  w_raw;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_estavel;
    logic [c_largura-1:0]  r_cont;

    assign w_raw = ATIVO_BAIXO ? ~raw : raw;

    // A change is accepted on the cycle the mismatch count would reach DEBOUNCE_CYCLES.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_estavel <= 1'b0;
            r_cont    <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_estavel) begin
                r_cont <= '0;
            end else if (r_cont == c_ultimo) begin
                r_estavel <= r_sync2;
                r_cont    <= '0;
            end else begin
                r_cont <= r_cont + c_largura'(1);
            end
        end
    end

    assign estavel = r_estavel;

endmodule

`default_nettype wire

// File: rtl/codificador_botoes.sv
// ============================================================================
//  Module   : codificador_botoes
//  Purpose  : Debounces 12 note keys and 2 arrows; emits one note code and arrow pulses.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module codificador_botoes
    import codificador_botoes_pkg::*;
#(
    parameter int CLOCK_FREQ      = 50000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int DEBOUNCE_CYCLES = CLOCK_FREQ / 1000 * DEBOUNCE_MS,
    parameter bit ATIVO_BAIXO     = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    codificador_botoes_if.slave    bus
);

    localparam int c_num_entradas = NUM_TECLAS + 2;

    logic [c_num_entradas-1:0] w_raw;
    logic [c_num_entradas-1:0] w_estavel;
    logic [NUM_TECLAS-1:0]     w_notas;
    logic [1:0]                w_setas;

    assign w_raw   = {bus.left_arrow_raw, bus.right_arrow_raw, bus.botoes_raw};
    assign w_notas = w_estavel[NUM_TECLAS-1:0];
    assign w_setas = w_estavel[c_num_entradas-1:NUM_TECLAS];

    generate
        for (genvar g = 0; g < c_num_entradas; g++) begin : g_debouncer
            debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .ATIVO_BAIXO     (ATIVO_BAIXO)
            ) u_debouncer (
                .clock   (clock),
                .reset   (reset),
                .raw     (w_raw[g]),
                .estavel (w_estavel[g])
            );
        end
    endgenerate

    estado_t    r_estado, w_estado;
    logic [3:0] r_indice, w_indice;
    logic [3:0] r_codigo, w_codigo;
    logic       r_valida;
    logic [1:0] r_setas_ant;
    logic [1:0] r_pulsos;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado    <= LIVRE;
            r_indice    <= 4'd0;
            r_codigo    <= NENHUMA_TECLA;
            r_valida    <= 1'b0;
            r_setas_ant <= 2'b00;
            r_pulsos    <= 2'b00;
        end else begin
            r_estado    <= w_estado;
            r_indice    <= w_indice;
            r_codigo    <= w_codigo;
            r_valida    <= (w_codigo != NENHUMA_TECLA);
            r_setas_ant <= w_setas;
            r_pulsos    <= w_setas & ~r_setas_ant;
        end
    end

    // Downward scan so the lowest pressed index is the one left standing.
    always_comb begin
        w_estado = r_estado;
        w_indice = r_indice;
        w_codigo = r_codigo;
        case (r_estado)
            LIVRE: begin
                w_codigo = NENHUMA_TECLA;
                for (int i = NUM_TECLAS - 1; i >= 0; i--) begin
                    if (w_notas[i]) begin
                        w_indice = 4'(i);
                        w_codigo = encode(4'(i));
                        w_estado = PRESA;
                    end
                end
            end
            PRESA: begin
                if (!w_notas[r_indice]) begin
                    w_codigo = NENHUMA_TECLA;
                    w_estado = LIVRE;
                end
            end
            default: begin
                w_codigo = NENHUMA_TECLA;
                w_estado = LIVRE;
            end
        endcase
    end

    assign bus.botoes_encoded      = r_codigo;
    assign bus.tecla_valida        = r_valida;
    assign bus.right_arrow_pressed = r_pulsos[0];
    assign bus.left_arrow_pressed  = r_pulsos[1];
    assign bus.db_estaveis         = w_estavel;

endmodule

`default_nettype wire

// File: tb/tb_codificador_botoes.sv
// ============================================================================
//  Module   : tb_codificador_botoes
//  Purpose  : Scoreboard bench for both key polarities against a window-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_codificador_botoes;
    import codificador_botoes_pkg::*;

    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] stim_notas = 12'h000;
    logic        stim_dir   = 1'b0;
    logic        stim_esq   = 1'b0;

    codificador_botoes_if bus_a ();
    codificador_botoes_if bus_b ();

    assign bus_a.botoes_raw      = stim_notas;
    assign bus_a.right_arrow_raw = stim_dir;
    assign bus_a.left_arrow_raw  = stim_esq;
    assign bus_b.botoes_raw      = ~stim_notas;
    assign bus_b.right_arrow_raw = ~stim_dir;
    assign bus_b.left_arrow_raw  = ~stim_esq;

    codificador_botoes #(.DEBOUNCE_CYCLES(DC), .ATIVO_BAIXO(1'b0)) dut_a (
        .clock (clock), .reset (reset), .bus (bus_a));
    codificador_botoes #(.DEBOUNCE_CYCLES(DC), .ATIVO_BAIXO(1'b1)) dut_b (
        .clock (clock), .reset (reset), .bus (bus_b));

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  codigo;
        logic        valida;
        logic        dir;
        logic        esq;
        logic [13:0] db;
    } saida_t;

    saida_t      fila[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          ciclo  = 0;

    // Reference: a level becomes stable once the last DC synchronised samples all agree on it.
    logic [13:0] hist[$];
    logic [13:0] m_st1 = '0;
    logic [13:0] m_st2 = '0;
    int          m_presa = -1;

    always @(posedge clock) begin : modelo
        saida_t      e;
        logic [13:0] amostra;
        logic [13:0] novo;
        logic        v;
        logic        b;
        bit          uniforme;
        int          n;
        int          idx;
        amostra = {stim_esq, stim_dir, stim_notas};
        e = '0;
        ciclo++;
        if (reset) begin
            hist.delete();
            m_st1   = '0;
            m_st2   = '0;
            m_presa = -1;
        end else begin
            if (m_presa >= 0) begin
                if (m_st1[m_presa]) e.codigo = 4'(m_presa + 1);
                else m_presa = -1;
            end else begin
                for (int k = 0; k < 12; k++) begin
                    if (m_st1[k]) begin
                        m_presa  = k;
                        e.codigo = 4'(k + 1);
                        break;
                    end
                end
            end
            e.valida = (e.codigo != 4'd0);
            e.dir    = m_st1[12] & ~m_st2[12];
            e.esq    = m_st1[13] & ~m_st2[13];
            novo = m_st1;
            n = hist.size();
            for (int k = 0; k < 14; k++) begin
                uniforme = 1'b1;
                v = 1'b0;
                for (int j = 0; j < DC; j++) begin
                    idx = n - 2 - j;
                    b = (idx >= 0) ? hist[idx][k] : 1'b0;
                    if (j == 0) v = b;
                    else if (b != v) uniforme = 1'b0;
                end
                if (uniforme && (v != m_st1[k])) novo[k] = v;
            end
            m_st2 = m_st1;
            m_st1 = novo;
            e.db  = novo;
            hist.push_back(amostra);
            if (hist.size() > DC + 1) void'(hist.pop_front());
        end
        fila.push_back(e);
    end

    always @(negedge clock) begin : monitor
        saida_t e;
        saida_t a;
        saida_t b;
        if (fila.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL fila_vazia ciclo %0d: no expected entry available", ciclo);
        end else begin
            e = fila.pop_front();
            a = {bus_a.botoes_encoded, bus_a.tecla_valida, bus_a.right_arrow_pressed,
                 bus_a.left_arrow_pressed, bus_a.db_estaveis};
            b = {bus_b.botoes_encoded, bus_b.tecla_valida, bus_b.right_arrow_pressed,
                 bus_b.left_arrow_pressed, bus_b.db_estaveis};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL saida_alto ciclo %0d: got %h expected %h", ciclo, a, e);
            end
            n_chk++;
            if (b !== e) begin
                n_fail++;
                $display("FAIL saida_baixo ciclo %0d: got %h expected %h", ciclo, b, e);
            end
        end
    end

    task automatic chk(input string nome, input int atual, input int esperado);
        n_chk++;
        if (atual != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nome, atual, esperado);
        end
    endtask

    task automatic chk_codigo(input string nome, input int esperado);
        chk({nome, "_alto"},  int'(bus_a.botoes_encoded), esperado);
        chk({nome, "_baixo"}, int'(bus_b.botoes_encoded), esperado);
        chk({nome, "_valida"}, int'(bus_a.tecla_valida), (esperado != 0) ? 1 : 0);
    endtask

    task automatic bordas(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single note: code appears at edge 7 and clears 7 edges after release
        stim_notas = 12'h020;
        bordas(6); chk_codigo("c1_antes", 0);
        bordas(1); chk_codigo("c1_press", 6);
        @(negedge clock) stim_notas = 12'h000;
        bordas(6); chk_codigo("c1_mantem", 6);
        bordas(1); chk_codigo("c1_solta", 0);
        repeat (4) @(negedge clock);

        // Bouncing note 3: three short highs never pass the filter
        for (int r = 0; r < 3; r++) begin
            stim_notas = 12'h008;
            repeat (3) @(negedge clock);
            stim_notas = 12'h000;
            @(negedge clock);
        end
        chk_codigo("c2_bounce", 0);
        stim_notas = 12'h008;
        bordas(6); chk_codigo("c2_antes", 0);
        bordas(1); chk_codigo("c2_press", 4);
        @(negedge clock) stim_notas = 12'h000;
        repeat (10) @(negedge clock);

        // Simultaneous notes 7 and 2, then release of 2
        stim_notas = 12'h084;
        bordas(7); chk_codigo("c3_menor", 3);
        @(negedge clock) stim_notas = 12'h080;
        bordas(6); chk_codigo("c3_mantem", 3);
        bordas(1); chk_codigo("c3_gap", 0);
        bordas(1); chk_codigo("c3_proxima", 8);
        @(negedge clock) stim_notas = 12'h000;
        repeat (10) @(negedge clock);

        // Latched note 9 ignores a later lower note
        stim_notas = 12'h200;
        bordas(7); chk_codigo("c4_nove", 10);
        @(negedge clock) stim_notas = 12'h202;
        bordas(10); chk_codigo("c4_ignora", 10);
        @(negedge clock) stim_notas = 12'h002;
        bordas(7); chk_codigo("c4_gap", 0);
        bordas(1); chk_codigo("c4_um", 2);
        @(negedge clock) stim_notas = 12'h000;
        repeat (10) @(negedge clock);

        // Both arrows held: one simultaneous pulse each
        stim_dir = 1'b1;
        stim_esq = 1'b1;
        bordas(6); chk("c5_dir_antes", int'(bus_a.right_arrow_pressed), 0);
        bordas(1); chk("c5_dir_pulso", int'(bus_a.right_arrow_pressed), 1);
        chk("c5_esq_pulso", int'(bus_b.left_arrow_pressed), 1);
        bordas(1); chk("c5_dir_fim", int'(bus_a.right_arrow_pressed), 0);
        repeat (13) @(negedge clock);
        stim_dir = 1'b0;
        stim_esq = 1'b0;
        repeat (10) @(negedge clock);

        // Reset while note 4 and right arrow are held
        stim_notas = 12'h010;
        stim_dir   = 1'b1;
        bordas(7); chk_codigo("c6_press", 5);
        @(negedge clock) reset = 1'b1;
        bordas(1); chk_codigo("c6_reset", 0);
        chk("c6_db_reset", int'(bus_a.db_estaveis), 0);
        @(negedge clock) reset = 1'b0;
        bordas(6); chk_codigo("c6_antes", 0);
        bordas(1); chk_codigo("c6_volta", 5);
        chk("c6_seta_volta", int'(bus_a.right_arrow_pressed), 1);
        @(negedge clock);
        stim_notas = 12'h000;
        stim_dir   = 1'b0;
        repeat (10) @(negedge clock);

        // Random traffic, including bounces, chords and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 5) == 0)
                stim_notas = stim_notas ^ (12'(1) << $urandom_range(0, 11));
            if ($urandom_range(0, 59) == 0)
                stim_notas = 12'($urandom()) & 12'($urandom());
            if ($urandom_range(0, 9) == 0) stim_dir = ~stim_dir;
            if ($urandom_range(0, 9) == 0) stim_esq = ~stim_esq;
        end
        @(negedge clock) reset = 1'b0;
        repeat (12) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
